if_fetch_unit: RTL
==================

# if_fetch_unit

Instruction-fetch stage with the IF/ID pipeline register. It holds the PC and issues one-at-a-time requests to instruction memory over a req/ack handshake. It computes redirect targets from the offsets produced by the immediate/jump extenders and delivers instruction plus PC+4 to the decode stage. It supports decode stalls, pipeline flush on redirect, and discarding of in-flight fetches.

## Interface
- RESET_PC, 32'h0000_3000, PC value after reset.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  decode stall; IF/ID register holds.
- redirect  in  1  taken branch/jump resolved this cycle.
- redirect_sel  in  2  target kind: `Npc_br, `Npc_j, `Npc_jr.
- redirect_pc4  in  32  PC+4 of the redirecting instruction.
- imm_ext  in  32  sign-extended 16-bit branch offset (unshifted).
- jump_ext  in  32  26-bit jump field, sign-extended and already shifted left by 2.
- jr_addr  in  32  register jump address.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address, word aligned.
- imem_ack  in  1  data valid and request accepted this cycle.
- imem_rdata  in  32  fetched instruction.
- id_valid  out  1  IF/ID contents are a real instruction.
- id_instr  out  32  instruction to decode.
- id_pc4  out  32  PC+4 of id_instr.

## Operation
- Targets, all modulo 2^32:
  - `Npc_br = redirect_pc4 + (imm_ext << 2).
  - `Npc_j = {redirect_pc4[31:28], jump_ext[27:0]}.
  - `Npc_jr = jr_addr, with bits [1:0] forced to 0.
- States:
  - S_RST: reset state. imem_req=0. Always moves to S_REQ on the next clock.
  - S_REQ: imem_req=1, imem_addr=pc. Address stays stable until ack.
  - S_HOLD: fetched word is parked in a one-entry buffer (buf_instr, buf_pc4). imem_req=0.
  - S_DROP: a redirect arrived while a request was outstanding. imem_req=1 with the old address; the returning data is discarded.
- IF/ID is "free" when id_valid=0 or stall=0.
- S_REQ, ack, no redirect:
  - If IF/ID is free, load id_instr=imem_rdata, id_pc4=pc+4, id_valid=1.
  - Otherwise write the buffer and go to S_HOLD.
  - pc<=pc+4 in both cases.
- S_REQ with no ack, stall=0: id_valid<=0 (bubble).
- S_HOLD, stall=0: move the buffer into IF/ID and go to S_REQ. While stall=1, hold.
- Redirect has the highest priority:
  - pc<=target and id_valid<=0. This applies even when stall=1, which does not block a flush.
  - The buffer is discarded.
  - From S_REQ without ack, go to S_DROP. From S_REQ with ack, the data is discarded and the state stays S_REQ.
  - From S_HOLD or S_DROP, go to S_REQ. In S_DROP the outstanding request still has to complete, so that transition happens on ack only; otherwise stay in S_DROP with the target latched.
- A second redirect while in S_DROP overwrites the latched target.
- While IF/ID holds, id_instr and id_pc4 do not change.

## Timing
- Reset values: pc=RESET_PC, state=S_RST, imem_req=0, id_valid=0, id_instr=0, id_pc4=0, buffer=0.
- First request goes out one cycle after rst deasserts.
- Zero-wait memory (ack in the same cycle as req): one instruction per cycle. A word acked in cycle n appears on id_* in cycle n+1.
- Redirect in cycle n:
  - id_valid=0 in cycle n+1.
  - Request to the target starts in n+1, or in the cycle after the outstanding ack if in S_DROP.
- At most one outstanding request, so imem_ack is meaningful only while imem_req=1.
- rst asserted mid-fetch aborts immediately: imem_req drops asynchronously and any in-flight ack is ignored.

## Structure
- Put `Npc_br, `Npc_j, `Npc_jr, the state encodings and the default RESET_PC in the shared define.v.
- One sub-module, npc_calc: combinational target mux plus the pc+4 adder.
- Top level holds the FSM, PC, buffer and IF/ID registers.

## Test plan
- **Reset and stream:** release reset with ack tied to 1.
  - imem_addr = 3000, 3004, 3008, … from cycle 1.
  - id_pc4 = 3004, 3008, … one cycle later.
- **Branch:** redirect with `Npc_br, redirect_pc4=3010, imm_ext=FFFF_FFFC.
  - Next imem_addr = 3000.
  - id_valid=0 for one cycle.
- **Jump and jr:**
  - `Npc_j, redirect_pc4=8000_0004, jump_ext=0000_0400 -> target 8000_0400.
  - `Npc_jr, jr_addr=0000_4007 -> target 0000_4004.
- **Stall with parked word:** IF/ID valid, stall=1, ack for 3008.
  - State moves to S_HOLD; id_* unchanged.
  - After stall drops, id_pc4=300C and fetch of 300C begins.
- **Redirect during wait:** ack delayed 3 cycles, redirect to 5000 in the first wait cycle.
  - imem_addr stays at the old value until ack.
  - The returned word never reaches id_valid=1.
  - Next request is to 5000.
- **Redirect during stall:** stall=1 and redirect in the same cycle.
  - id_valid=0 next cycle.
  - The buffer is discarded and no parked word reaches IF/ID.

Source files
------------

// File: rtl/if_fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: redirect target kinds,
// fetch FSM state encodings and the default reset PC.
package if_fetch_unit_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

    typedef enum logic [1:0] {
        NPC_BR = 2'd0,
        NPC_J  = 2'd1,
        NPC_JR = 2'd2
    } npc_sel_e;

    typedef enum logic [1:0] {
        S_RST  = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2,
        S_DROP = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/if_fetch_unit_npc_calc.sv
// Combinational next-PC logic: sequential pc+4 and the redirect target mux
// for branch, jump and register-jump destinations.
module npc_calc
    import if_fetch_unit_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [1:0]  redirect_sel,
    input  logic [31:0] redirect_pc4,
    input  logic [31:0] imm_ext,
    input  logic [31:0] jump_ext,
    input  logic [31:0] jr_addr,
    output logic [31:0] pc_plus4,
    output logic [31:0] target
);

    assign pc_plus4 = pc + 32'd4;

    // An unused selector encoding falls through to the sequential successor.
    always_comb begin
        target = redirect_pc4;
        case (redirect_sel)
            NPC_BR:  target = redirect_pc4 + (imm_ext << 2);
            NPC_J:   target = (redirect_pc4 & 32'hF000_0000) | (jump_ext & 32'h0FFF_FFFF);
            NPC_JR:  target = jr_addr & 32'hFFFF_FFFC;
            default: target = redirect_pc4;
        endcase
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: PC, single-outstanding imem req/ack handshake,
// one-entry park buffer for stalled returns, and the IF/ID pipeline register.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [1:0]  redirect_sel,
    input  logic [31:0] redirect_pc4,
    input  logic [31:0] imm_ext,
    input  logic [31:0] jump_ext,
    input  logic [31:0] jr_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc4
);

    fetch_state_e state, state_next;

    logic [31:0] pc, pc_next;
    logic [31:0] drop_addr, drop_addr_next;
    logic [31:0] buf_instr, buf_instr_next;
    logic [31:0] buf_pc4, buf_pc4_next;
    logic        id_valid_next;
    logic [31:0] id_instr_next, id_pc4_next;
    logic [31:0] pc_plus4, target;
    logic        if_id_free;

    npc_calc u_npc_calc (
        .pc           (pc),
        .redirect_sel (redirect_sel),
        .redirect_pc4 (redirect_pc4),
        .imm_ext      (imm_ext),
        .jump_ext     (jump_ext),
        .jr_addr      (jr_addr),
        .pc_plus4     (pc_plus4),
        .target       (target)
    );

    assign if_id_free = !id_valid || !stall;
    assign imem_req   = (state == S_REQ) || (state == S_DROP);
    // While draining a dropped fetch the old address must stay on the bus.
    assign imem_addr  = ((state == S_DROP) ? drop_addr : pc) & 32'hFFFF_FFFC;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_RST;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next     = state;
        pc_next        = pc;
        drop_addr_next = drop_addr;
        buf_instr_next = buf_instr;
        buf_pc4_next   = buf_pc4;
        id_valid_next  = id_valid;
        id_instr_next  = id_instr;
        id_pc4_next    = id_pc4;

        // A redirect flushes IF/ID even under stall; the outstanding request,
        // if any, still has to be acked before the target can be requested.
        if (redirect) begin
            pc_next       = target;
            id_valid_next = 1'b0;
            case (state)
                S_REQ: begin
                    if (!imem_ack) begin
                        state_next     = S_DROP;
                        drop_addr_next = pc;
                    end
                end
                S_DROP: begin
                    if (imem_ack) begin
                        state_next = S_REQ;
                    end
                end
                default: state_next = S_REQ;
            endcase
        end else begin
            case (state)
                S_RST: state_next = S_REQ;
                S_REQ: begin
                    if (imem_ack) begin
                        pc_next = pc_plus4;
                        if (if_id_free) begin
                            id_valid_next = 1'b1;
                            id_instr_next = imem_rdata;
                            id_pc4_next   = pc_plus4;
                        end else begin
                            buf_instr_next = imem_rdata;
                            buf_pc4_next   = pc_plus4;
                            state_next     = S_HOLD;
                        end
                    end else if (!stall) begin
                        id_valid_next = 1'b0;
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        id_valid_next = 1'b1;
                        id_instr_next = buf_instr;
                        id_pc4_next   = buf_pc4;
                        state_next    = S_REQ;
                    end
                end
                S_DROP: begin
                    if (imem_ack) begin
                        state_next = S_REQ;
                    end
                end
                default: state_next = S_RST;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc        <= RESET_PC;
            drop_addr <= 32'd0;
            buf_instr <= 32'd0;
            buf_pc4   <= 32'd0;
            id_valid  <= 1'b0;
            id_instr  <= 32'd0;
            id_pc4    <= 32'd0;
        end else begin
            pc        <= pc_next;
            drop_addr <= drop_addr_next;
            buf_instr <= buf_instr_next;
            buf_pc4   <= buf_pc4_next;
            id_valid  <= id_valid_next;
            id_instr  <= id_instr_next;
            id_pc4    <= id_pc4_next;
        end
    end

endmodule
